phy_rx_sync_ctrl: RTL
=====================

Name: phy_rx_sync_ctrl

Overview:
Byte-level link controller for the two-lane RX PHY. It takes aligned bytes from the per-lane serial-to-parallel stages, which run in the same clock domain. It runs a per-lane comma-lock state machine and declares the link active once both lanes are locked. When active, it merges lane bytes into 16-bit data words and strips control symbols. It sits between the lane deserializers and the downstream receive FIFO/demux.

Parameters:
COM, 8'hBC, comma/sync symbol
IDL, 8'h7C, idle symbol, sent when no data
LOCK_CNT, 4, consecutive COMs per lane needed to lock
LOSS_CNT, 4, consecutive lane-mismatch events that drop lock

Ports:
clk  in  1  single system clock; byte-rate strobe rx_valid qualifies activity
reset  in  1  synchronous, active-low; reset==0 at posedge clk clears all state
enable  in  1  1=controller runs; 0=hold all state, outputs frozen
rx_byte_0  in  8  aligned byte from lane 0
rx_byte_1  in  8  aligned byte from lane 1
rx_valid  in  1  both lane bytes valid this cycle
data_out  out  16  {lane1 byte, lane0 byte}
valid_out  out  1  data_out valid, one-cycle pulse
active  out  1  both lanes locked
lock  out  2  per-lane lock status, bit i = lane i
err_mismatch  out  1  one-cycle pulse when lanes disagree on a control symbol while active

Behaviour:
- Reset (reset==0, synchronous): lanes go to HUNT; counters=0; data_out=16'h0; valid_out=0; active=0; lock=2'b00; err_mismatch=0. Reset has priority over enable.
- enable==0: no state or counter update. valid_out and err_mismatch forced 0. data_out, active and lock hold their values.
- Only cycles with rx_valid==1 and enable==1 advance the state machines. All other cycles hold.
- Per-lane FSM (lane i, byte b), states HUNT, LOCKING, LOCKED:
  - HUNT: b==COM -> LOCKING with cnt=1; otherwise stay.
  - LOCKING: b==COM -> cnt+1; when cnt+1==LOCK_CNT -> LOCKED. b!=COM -> HUNT with cnt=0.
  - LOCKED: stays until a global loss event.
- lock[i]=1 exactly while lane i is in LOCKED, registered. The 4th consecutive COM sets lock[i] on that clock edge.
- active=lock[0]&lock[1], registered in the same cycle as the second lane's lock.
- While active, each rx_valid cycle classifies both bytes as ctrl (COM or IDL) or data:
  - both data: data_out<={rx_byte_1,rx_byte_0}; valid_out=1 on the next cycle (latency 1).
  - both ctrl: no output; loss counter cleared.
  - one ctrl, one data: err_mismatch=1, no valid_out, loss counter +1.
  - both data also clears the loss counter.
  - loss counter reaching LOSS_CNT: both lanes -> HUNT, lock=0, active=0, counter cleared. This takes effect on that same edge.
- Bytes in the cycle where active first rises are not output; output starts with the next rx_valid.
- Lock counter width = $clog2(LOCK_CNT+1); loss counter width = $clog2(LOSS_CNT+1). Counters saturate and never wrap.
- A lane that locks alone stays LOCKED indefinitely while the other hunts. No timeout.
- Reset asserted mid-stream: all outputs are cleared on that edge, and any in-flight word is discarded.

Decomposition:
- Package phy_rx_pkg: COM/IDL constants, lane state enum {HUNT, LOCKING, LOCKED}, and an is_ctrl function.
- Sub-module phy_rx_lane_lock, instanced twice: contains the per-lane FSM and lock counter, with inputs byte, step and force_hunt.
- The top level holds the active logic, classifier, loss counter and output register.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random input -> all outputs 0, lock=00.
- Lock: both lanes send COM on 4 rx_valid cycles -> lock=11 and active=1 after the 4th edge. Then send {8'h5A,8'hA5} -> data_out=16'h5AA5 with valid_out=1 one cycle later.
- Partial lock: lane0 sends 3 COMs, then 8'h00, then 4 COMs; lane1 sends 4 COMs -> lock[1] at cycle 4, lock[0] only at cycle 8, active at cycle 8.
- Control stripping: while active, send IDL/IDL and COM/COM -> valid_out stays 0 and err_mismatch stays 0.
- Loss of lock: while active, send 4 consecutive COM/data pairs {8'hBC,8'h11} -> 4 err_mismatch pulses, then active=0, lock=00. A subsequent 4-COM sequence relocks.
- Enable/reset mid-stream: enable=0 for 3 cycles during LOCKING (cnt=2), then resume with 2 COMs -> locked. Repeat with reset=0 instead -> 4 COMs are needed after reset.

Source files
------------

// File: rtl/phy_rx_pkg.sv
// Shared symbols, lane FSM encodings and the control-symbol classifier
// for the two-lane RX link controller.
package phy_rx_pkg;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] IDL = 8'h7C;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 4;

  localparam int LOCK_W = $clog2(LOCK_CNT + 1);
  localparam int LOSS_W = $clog2(LOSS_CNT + 1);

  // Lane state encodings, kept as plain constants for legacy tools.
  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] LOCKING = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  typedef logic [1:0] lane_state_t;

  // Control symbols are stripped from the data stream.
  function automatic logic is_ctrl(input logic [7:0] b);
    return (b == COM) || (b == IDL);
  endfunction

endpackage

// File: rtl/phy_rx_lane_lock.sv
// Per-lane comma-lock FSM: counts consecutive COM symbols on qualified
// cycles and reports lock once LOCK_CNT have been seen in a row.
module phy_rx_lane_lock
  import phy_rx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       step,
  input  logic       force_hunt,
  output logic       lock
);

  localparam logic [LOCK_W-1:0] LOCK_TARGET = LOCK_W'(LOCK_CNT);
  localparam logic [LOCK_W-1:0] CNT_ONE     = LOCK_W'(1);

  lane_state_t       state_reg;
  logic [LOCK_W-1:0] cnt_reg;
  logic [LOCK_W-1:0] cnt_inc;
  logic              is_com;

  assign is_com  = (rx_byte == COM);
  // Saturating increment so the counter can never wrap.
  assign cnt_inc = (cnt_reg == LOCK_TARGET) ? cnt_reg : cnt_reg + CNT_ONE;

  // Lane state and lock counter; a global loss event overrides stepping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= HUNT;
      cnt_reg   <= '0;
    end else if (force_hunt) begin
      state_reg <= HUNT;
      cnt_reg   <= '0;
    end else if (step) begin
      case (state_reg)
        HUNT: begin
          if (is_com) begin
            cnt_reg   <= CNT_ONE;
            state_reg <= (CNT_ONE == LOCK_TARGET) ? LOCKED : LOCKING;
          end
        end
        LOCKING: begin
          if (is_com) begin
            cnt_reg <= cnt_inc;
            if (cnt_inc == LOCK_TARGET) begin
              state_reg <= LOCKED;
            end
          end else begin
            cnt_reg   <= '0;
            state_reg <= HUNT;
          end
        end
        LOCKED: begin
          state_reg <= LOCKED;
        end
        default: begin
          state_reg <= HUNT;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign lock = (state_reg == LOCKED);

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// Two-lane RX link controller: per-lane comma lock, link-active
// detection, 16-bit word merge with control stripping and loss-of-lock.
module phy_rx_sync_ctrl
  import phy_rx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  rx_byte_0,
  input  logic [7:0]  rx_byte_1,
  input  logic        rx_valid,
  output logic [15:0] data_out,
  output logic        valid_out,
  output logic        active,
  output logic [1:0]  lock,
  output logic        err_mismatch
);

  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_CNT - 1);
  localparam logic [LOSS_W-1:0] LOSS_ONE  = LOSS_W'(1);

  logic [7:0]        lane_byte [2];
  logic              step;
  logic              ctrl_0;
  logic              ctrl_1;
  logic              both_data;
  logic              mismatch;
  logic              loss_last;
  logic              force_hunt;
  logic [LOSS_W-1:0] loss_cnt_reg;
  logic [15:0]       data_reg;
  logic              valid_reg;
  logic              err_reg;

  assign lane_byte[0] = rx_byte_0;
  assign lane_byte[1] = rx_byte_1;
  assign step         = enable & rx_valid;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      phy_rx_lane_lock u_lane (
        .clk        (clk),
        .reset      (reset),
        .rx_byte    (lane_byte[gi]),
        .step       (step),
        .force_hunt (force_hunt),
        .lock       (lock[gi])
      );
    end
  endgenerate

  // Lock bits are registered, so active is low during the cycle in which
  // it first rises and those bytes are never forwarded.
  assign active = lock[0] & lock[1];

  assign ctrl_0     = is_ctrl(rx_byte_0);
  assign ctrl_1     = is_ctrl(rx_byte_1);
  assign both_data  = !ctrl_0 && !ctrl_1;
  assign mismatch   = ctrl_0 ^ ctrl_1;
  assign loss_last  = (loss_cnt_reg == LOSS_LAST);
  assign force_hunt = active && step && mismatch && loss_last;

  // Word merge, mismatch pulse and loss counter on qualified active cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
      loss_cnt_reg <= '0;
    end else begin
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      if (step && active) begin
        if (both_data) begin
          data_reg     <= {rx_byte_1, rx_byte_0};
          valid_reg    <= 1'b1;
          loss_cnt_reg <= '0;
        end else if (mismatch) begin
          err_reg      <= 1'b1;
          loss_cnt_reg <= loss_last ? '0 : loss_cnt_reg + LOSS_ONE;
        end else begin
          loss_cnt_reg <= '0;
        end
      end
    end
  end

  // Pulses are suppressed immediately while the controller is paused.
  assign data_out     = data_reg;
  assign valid_out    = valid_reg & enable;
  assign err_mismatch = err_reg & enable;

endmodule
